led_pulse_stretcher: RTL and testbench

- Output-side counterpart to the button debounce/edge-pulse input path.
- Takes single-cycle event pulses plus steady level requests per LED.
- Stretches each pulse to a human-visible hold time and applies global PWM dimming.
- Drives the board LED pins from registers. Instantiated between LED-producing logic (switcher, toggler, mode mux) and the led_o pins of the board top.

---
 rtl/led_pulse_stretcher.sv | 92 +++++++++
 tb/tb_led_pulse_stretcher.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/led_pulse_stretcher.sv
// Stretches per-LED event pulses to a visible hold time and applies global PWM dimming.
// Latency: level_i->led_o 1 cycle, pulse_i->led_o 2 cycles; no backpressure, inputs are always accepted.
module led_pulse_stretcher #(
    parameter int NumLeds    = 4,
    parameter int HoldCycles = 5000000,
    parameter int PwmWidth   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumLeds-1:0]  pulse_i,
    input  logic [NumLeds-1:0]  level_i,
    input  logic [PwmWidth-1:0] duty_i,
    output logic [NumLeds-1:0]  led_o,
    output logic [NumLeds-1:0]  busy_o
);

    localparam int CntW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
    localparam logic [CntW-1:0]     HoldLoad = CntW'(HoldCycles - 1);
    localparam logic [PwmWidth-1:0] PwmMax   = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hold_st_e;

    logic [NumLeds-1:0] busy_q;

    // One independent hold FSM per channel; a pulse in HOLD reloads rather than accumulates.
    for (genvar k = 0; k < NumLeds; k++) begin : g_ch
        hold_st_e        st;
        logic [CntW-1:0] cnt;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                st        <= ST_IDLE;
                cnt       <= '0;
                busy_q[k] <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (pulse_i[k]) begin
                            st        <= ST_HOLD;
                            cnt       <= HoldLoad;
                            busy_q[k] <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (pulse_i[k]) begin
                            cnt <= HoldLoad;
                        end else if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            st        <= ST_IDLE;
                            busy_q[k] <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign busy_o = busy_q;

    logic [PwmWidth-1:0] pwm_cnt;
    logic [PwmWidth-1:0] duty_q;
    logic                pwm_on;

    // Duty only changes at the period boundary so a period is never cut short or stretched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwm_cnt <= '0;
            duty_q  <= '1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == PwmMax) begin
                duty_q <= duty_i;
            end
        end
    end

    // All-ones duty means fully on, not (2^N-1)/2^N.
    assign pwm_on = (duty_q == PwmMax) || (pwm_cnt < duty_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_o <= '0;
        end else begin
            led_o <= (level_i | busy_q) & {NumLeds{pwm_on}};
        end
    end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with HoldCycles=4, PwmWidth=3.
// Cycle 0 is the half-cycle right after reset release; pwm_cnt equals cyc mod 8 from there.
module tb_led_pulse_stretcher;

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b1;
    logic [3:0] pulse_i = '0;
    logic [3:0] level_i = '0;
    logic [2:0] duty_i  = 3'd7;
    logic [3:0] led_o;
    logic [3:0] busy_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk_i = ~clk_i;

    led_pulse_stretcher #(
        .NumLeds    (4),
        .HoldCycles (4),
        .PwmWidth   (3)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .pulse_i (pulse_i),
        .level_i (level_i),
        .duty_i  (duty_i),
        .led_o   (led_o),
        .busy_o  (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        pulse_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_led", 32'(led_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        // Isolated pulse on LED 0 at cycle 10
        duty_i  = 3'd7;
        level_i = '0;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) step();
            chk("t1_busy", 32'(busy_o), (c >= 11 && c <= 14) ? 32'h1 : 32'h0);
            chk("t1_led", 32'(led_o), (c >= 12 && c <= 15) ? 32'h1 : 32'h0);
            pulse_i = (c == 10) ? 4'b0001 : 4'b0000;
        end

        // Retrigger on LED 1 at cycles 10 and 12
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) step();
            chk("t2_busy", 32'(busy_o), (c >= 11 && c <= 16) ? 32'h2 : 32'h0);
            chk("t2_led", 32'(led_o), (c >= 12 && c <= 17) ? 32'h2 : 32'h0);
            pulse_i = (c == 10 || c == 12) ? 4'b0010 : 4'b0000;
        end

        // PWM: duty 3 applied mid-period, then duty 0
        level_i = 4'hF;
        duty_i  = 3'd7;
        do_reset();
        for (int c = 0; c <= 60; c++) begin
            logic [3:0] exp_led;
            if (c > 0) step();
            if (c == 0)       exp_led = 4'h0;
            else if (c <= 8)  exp_led = 4'hF;
            else if (c <= 43) exp_led = (((c - 1) % 8) < 3) ? 4'hF : 4'h0;
            else              exp_led = 4'h0;
            chk("t3_pwm_led", 32'(led_o), 32'(exp_led));
            if (c == 4)  duty_i = 3'd3;
            if (c == 40) duty_i = 3'd0;
        end

        // Level on LED 2 handing over to a hold without a gap
        level_i = '0;
        duty_i  = 3'd7;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) step();
            chk("t4_busy", 32'(busy_o), (c >= 11 && c <= 14) ? 32'h4 : 32'h0);
            chk("t4_led", 32'(led_o), (c >= 1 && c <= 15) ? 32'h4 : 32'h0);
            level_i = (c <= 11) ? 4'b0100 : 4'b0000;
            pulse_i = (c == 10) ? 4'b0100 : 4'b0000;
        end

        // Asynchronous reset in the middle of a hold on all LEDs
        level_i = '0;
        duty_i  = 3'd7;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) step();
            chk("t5_pre_busy", 32'(busy_o), (c >= 11) ? 32'hF : 32'h0);
            chk("t5_pre_led", 32'(led_o), (c >= 12) ? 32'hF : 32'h0);
            pulse_i = (c == 10) ? 4'hF : 4'h0;
        end
        #2;
        rst_i = 1'b1;
        #1;
        chk("t5_async_led", 32'(led_o), 32'h0);
        chk("t5_async_busy", 32'(busy_o), 32'h0);
        // duty_i=0 after release: only a full-brightness reset duty_q lights LEDs for the first period
        level_i = 4'b1100;
        duty_i  = 3'd0;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) step();
            chk("t5_post_led", 32'(led_o), (c >= 1 && c <= 8) ? 32'hC : 32'h0);
            chk("t5_post_busy", 32'(busy_o), 32'h0);
        end

        // Pulses held for 3 cycles on all LEDs
        level_i = '0;
        duty_i  = 3'd7;
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) step();
            chk("t6_busy", 32'(busy_o), (c >= 11 && c <= 16) ? 32'hF : 32'h0);
            chk("t6_led", 32'(led_o), (c >= 12 && c <= 17) ? 32'hF : 32'h0);
            pulse_i = (c >= 10 && c <= 12) ? 4'hF : 4'h0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
